// File: rtl/synth_pkg.sv
// Shared types and width constants for the voice allocation path.
// Imported by the allocator and its helpers.
package synth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SEARCH,
    KILL,
    WRITE
  } state_e;

  localparam int unsigned KEY_BITS         = 7;
  localparam int unsigned VEL_BITS         = 32;
  localparam int unsigned WORD_BITS        = 18;
  localparam int unsigned DEFAULT_CHANNELS = 16;
  localparam int unsigned STEAL_MAX        = 255;

endpackage

// File: rtl/voice_priority_enc.sv
// Lowest-set-bit encoder: reports whether any request bit is set, the index of
// the lowest one, and that bit alone as a one-hot mask.
module voice_priority_enc #(
  parameter int unsigned NUM_CHANNELS = 16
) (
  input  logic [NUM_CHANNELS-1:0]         i_mask,
  output logic                            o_found,
  output logic [$clog2(NUM_CHANNELS)-1:0] o_index,
  output logic [NUM_CHANNELS-1:0]         o_onehot
);
  localparam int unsigned IdxW = $clog2(NUM_CHANNELS);

  // Scan from the top so the lowest set bit is the last one assigned.
  always_comb begin
    o_index = '0;
    for (int i = NUM_CHANNELS - 1; i >= 0; i--) begin
      if (i_mask[i]) o_index = IdxW'(i);
    end
  end

  assign o_found  = |i_mask;
  assign o_onehot = i_mask & (~i_mask + NUM_CHANNELS'(1));

endmodule

// File: rtl/voice_allocator.sv
// Note-event voice allocator: picks a channel per event, steals round-robin when
// every voice is busy, and drives the note register bank write strobes.
module voice_allocator
  import synth_pkg::*;
#(
  parameter int unsigned NUM_CHANNELS  = DEFAULT_CHANNELS,
  parameter int unsigned NUM_BITS_WORD = WORD_BITS,
  parameter int unsigned NUM_BITS_KEY  = KEY_BITS,
  parameter int unsigned NUM_BITS_VEL  = VEL_BITS
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic                                 ev_valid,
  output logic                                 ev_ready,
  input  logic                                 ev_on,
  input  logic [NUM_BITS_KEY-1:0]              ev_key,
  input  logic [NUM_BITS_WORD-1:0]             ev_word,
  input  logic [NUM_BITS_VEL-1:0]              ev_velocity,
  input  logic [NUM_CHANNELS-1:0]              available,
  output logic [NUM_CHANNELS-1:0]              reg_en,
  output logic [NUM_CHANNELS-1:0]              note_en,
  output logic [NUM_BITS_WORD-1:0]             note_out,
  output logic [NUM_BITS_VEL*NUM_CHANNELS-1:0] velocity_out,
  output logic [7:0]                           steal_count
);
  localparam int unsigned IdxW = $clog2(NUM_CHANNELS);

  state_e                            r_state, w_state_next;
  logic                              r_on;
  logic [NUM_BITS_KEY-1:0]           r_key;
  logic [NUM_BITS_WORD-1:0]          r_word;
  logic [NUM_BITS_VEL-1:0]           r_vel;
  logic [IdxW-1:0]                   r_target, r_steal_ptr;
  logic [NUM_CHANNELS-1:0]           r_target_oh, r_key_valid, r_note_en, r_reg_en;
  logic [NUM_BITS_KEY-1:0]           r_keys [NUM_CHANNELS];
  logic [NUM_BITS_WORD-1:0]          r_note_out;
  logic [NUM_BITS_VEL*NUM_CHANNELS-1:0] r_velocity_out;
  logic [7:0]                        r_steal_count;

  logic                    w_accept, w_wr_en, w_clr_en, w_steal;
  logic [IdxW-1:0]         w_target, w_free_idx, w_match_idx;
  logic [NUM_CHANNELS-1:0] w_target_oh, w_free_mask, w_free_oh, w_match_mask, w_match_oh;
  logic                    w_free_found, w_match_found;

  assign ev_ready = (r_state == IDLE) && !rst;
  assign w_accept = ev_valid && ev_ready;

  assign w_free_mask = available & ~r_key_valid;

  always_comb begin
    w_match_mask = '0;
    for (int c = 0; c < NUM_CHANNELS; c++) begin
      w_match_mask[c] = r_key_valid[c] && (r_keys[c] == r_key);
    end
  end

  voice_priority_enc #(.NUM_CHANNELS(NUM_CHANNELS)) u_free_enc (
    .i_mask   (w_free_mask),
    .o_found  (w_free_found),
    .o_index  (w_free_idx),
    .o_onehot (w_free_oh)
  );

  voice_priority_enc #(.NUM_CHANNELS(NUM_CHANNELS)) u_match_enc (
    .i_mask   (w_match_mask),
    .o_found  (w_match_found),
    .o_index  (w_match_idx),
    .o_onehot (w_match_oh)
  );

  // Retrigger takes priority over a free channel; stealing is the last resort.
  always_comb begin
    w_state_next = r_state;
    w_target     = r_steal_ptr;
    w_target_oh  = NUM_CHANNELS'(1) << r_steal_ptr;
    w_wr_en      = 1'b0;
    w_clr_en     = 1'b0;
    w_steal      = 1'b0;
    unique case (r_state)
      IDLE: if (w_accept) w_state_next = SEARCH;
      SEARCH: begin
        if (r_on && w_match_found) begin
          w_target     = w_match_idx;
          w_target_oh  = w_match_oh;
          w_clr_en     = 1'b1;
          w_state_next = KILL;
        end else if (r_on && w_free_found) begin
          w_target     = w_free_idx;
          w_target_oh  = w_free_oh;
          w_wr_en      = 1'b1;
          w_state_next = WRITE;
        end else if (r_on) begin
          w_steal      = 1'b1;
          w_clr_en     = 1'b1;
          w_state_next = KILL;
        end else begin
          w_target     = w_match_idx;
          w_target_oh  = w_match_oh;
          w_clr_en     = w_match_found;
          w_state_next = IDLE;
        end
      end
      KILL: begin
        w_target     = r_target;
        w_target_oh  = r_target_oh;
        w_wr_en      = 1'b1;
        w_state_next = WRITE;
      end
      WRITE:   w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_on           <= 1'b0;
      r_key          <= '0;
      r_word         <= '0;
      r_vel          <= '0;
      r_target       <= '0;
      r_target_oh    <= '0;
      r_key_valid    <= '0;
      r_note_en      <= '0;
      r_reg_en       <= '0;
      r_note_out     <= '0;
      r_velocity_out <= '0;
      r_steal_ptr    <= '0;
      r_steal_count  <= '0;
      for (int c = 0; c < NUM_CHANNELS; c++) r_keys[c] <= '0;
    end else begin
      r_reg_en <= '0;
      if (w_accept) begin
        r_on   <= ev_on;
        r_key  <= ev_key;
        r_word <= ev_word;
        r_vel  <= ev_velocity;
      end
      if (r_state == SEARCH) begin
        r_target    <= w_target;
        r_target_oh <= w_target_oh;
      end
      if (w_clr_en) begin
        r_note_en   <= r_note_en & ~w_target_oh;
        r_key_valid <= r_key_valid & ~w_target_oh;
      end
      if (w_wr_en) begin
        r_reg_en    <= w_target_oh;
        r_note_out  <= r_word;
        r_velocity_out[int'(w_target)*NUM_BITS_VEL +: NUM_BITS_VEL] <= r_vel;
        r_keys[w_target] <= r_key;
        r_note_en   <= r_note_en | w_target_oh;
        r_key_valid <= r_key_valid | w_target_oh;
      end
      if (w_steal) begin
        r_steal_ptr <= (r_steal_ptr == IdxW'(NUM_CHANNELS - 1)) ? '0 : r_steal_ptr + 1'b1;
        if (r_steal_count != 8'(STEAL_MAX)) r_steal_count <= r_steal_count + 8'd1;
      end
    end
  end

  assign reg_en       = r_reg_en;
  assign note_en      = r_note_en;
  assign note_out     = r_note_out;
  assign velocity_out = r_velocity_out;
  assign steal_count  = r_steal_count;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboard bench for voice_allocator: a channel-level reference model predicts
// each write and gate drop, and a monitor matches them against the DUT outputs.
module tb_voice_allocator;
  localparam int NCH = 16;
  localparam int WW  = 18;
  localparam int KW  = 7;
  localparam int VW  = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              ev_valid = 1'b0;
  logic              ev_ready;
  logic              ev_on = 1'b0;
  logic [KW-1:0]     ev_key = '0;
  logic [WW-1:0]     ev_word = '0;
  logic [VW-1:0]     ev_velocity = '0;
  logic [NCH-1:0]    available = '1;
  logic [NCH-1:0]    reg_en;
  logic [NCH-1:0]    note_en;
  logic [WW-1:0]     note_out;
  logic [VW*NCH-1:0] velocity_out;
  logic [7:0]        steal_count;

  voice_allocator #(
    .NUM_CHANNELS  (NCH),
    .NUM_BITS_WORD (WW),
    .NUM_BITS_KEY  (KW),
    .NUM_BITS_VEL  (VW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .ev_valid     (ev_valid),
    .ev_ready     (ev_ready),
    .ev_on        (ev_on),
    .ev_key       (ev_key),
    .ev_word      (ev_word),
    .ev_velocity  (ev_velocity),
    .available    (available),
    .reg_en       (reg_en),
    .note_en      (note_en),
    .note_out     (note_out),
    .velocity_out (velocity_out),
    .steal_count  (steal_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0;
  int n_err = 0;

  typedef struct {
    int                cyc;
    int                ch;
    logic [WW-1:0]     word;
    logic [VW*NCH-1:0] vel;
    logic [NCH-1:0]    gates;
    logic [7:0]        steals;
  } wr_t;

  typedef struct {
    int             cyc;
    int             ch;
    logic [NCH-1:0] gates;
  } fl_t;

  wr_t wq[$];
  fl_t fq[$];

  // Reference model: what each voice holds, independent of any state machine.
  logic [KW-1:0]  m_key [NCH];
  logic [VW-1:0]  m_vel [NCH];
  logic [NCH-1:0] m_gate;
  int             m_ptr;
  int             m_steals;

  task automatic chk(input string name, input logic [VW*NCH-1:0] act,
                     input logic [VW*NCH-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_key[i] = '0;
      m_vel[i] = '0;
    end
    m_gate   = '0;
    m_ptr    = 0;
    m_steals = 0;
  endtask

  task automatic push_fall(input int c, input int t);
    fl_t f;
    m_gate[c] = 1'b0;
    f.cyc   = t;
    f.ch    = c;
    f.gates = m_gate;
    fq.push_back(f);
  endtask

  task automatic push_write(input int c, input logic [KW-1:0] k, input logic [WW-1:0] w,
                            input logic [VW-1:0] v, input int t);
    wr_t r;
    m_gate[c] = 1'b1;
    m_key[c]  = k;
    m_vel[c]  = v;
    r.cyc    = t;
    r.ch     = c;
    r.word   = w;
    for (int i = 0; i < NCH; i++) r.vel[i*VW +: VW] = m_vel[i];
    r.gates  = m_gate;
    r.steals = 8'(m_steals);
    wq.push_back(r);
  endtask

  task automatic model_event(input bit on, input logic [KW-1:0] k, input logic [WW-1:0] w,
                             input logic [VW-1:0] v, input logic [NCH-1:0] av, input int t);
    int c = -1;
    for (int i = 0; i < NCH; i++) if (c < 0 && m_gate[i] && m_key[i] == k) c = i;
    if (!on) begin
      if (c >= 0) push_fall(c, t + 2);
    end else if (c >= 0) begin
      push_fall(c, t + 2);
      push_write(c, k, w, v, t + 3);
    end else begin
      for (int i = 0; i < NCH; i++) if (c < 0 && av[i] && !m_gate[i]) c = i;
      if (c >= 0) begin
        push_write(c, k, w, v, t + 2);
      end else begin
        c = m_ptr;
        m_ptr = (m_ptr + 1) % NCH;
        if (m_steals < 255) m_steals++;
        if (m_gate[c]) push_fall(c, t + 2);
        push_write(c, k, w, v, t + 3);
      end
    end
  endtask

  // Called at a falling edge; the event is held until the allocator is ready.
  task automatic send(input bit on, input int key, input logic [WW-1:0] w,
                      input logic [VW-1:0] v, input logic [NCH-1:0] av, input bit busy_chk);
    int n = 0;
    int t;
    ev_on       = on;
    ev_key      = KW'(key);
    ev_word     = w;
    ev_velocity = v;
    ev_valid    = 1'b1;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!ev_ready) begin
      n_vec++;
      n_err++;
      $display("FAIL ready_timeout: ev_ready=0 after 50 cycles, required 1");
      ev_valid = 1'b0;
      return;
    end
    available = av;
    t = cyc;
    model_event(on, KW'(key), w, v, av, t);
    @(negedge clk);
    ev_valid = 1'b0;
    if (busy_chk) begin
      chk("busy_t1", ev_ready, 0);
      @(negedge clk);
      chk("busy_t2", ev_ready, 0);
    end
  endtask

  task automatic do_reset();
    rst      = 1'b1;
    ev_valid = 1'b0;
    wq.delete();
    fq.delete();
    model_reset();
    @(negedge clk);
    chk("rst_reg_en", reg_en, 0);
    chk("rst_note_en", note_en, 0);
    chk("rst_note_out", note_out, 0);
    chk("rst_velocity", velocity_out, 0);
    chk("rst_steal_count", steal_count, 0);
    chk("rst_ready_low", ev_ready, 0);
    rst       = 1'b0;
    available = '1;
    @(negedge clk);
    chk("post_rst_ready", ev_ready, 1);
    chk("post_rst_reg_en", reg_en, 0);
  endtask

  logic [NCH-1:0] mon_prev = '0;
  logic [NCH-1:0] mon_fell;
  bit             mon_rst;
  wr_t            mon_w;
  fl_t            mon_f;

  initial begin
    forever begin
      @(posedge clk);
      mon_rst = rst;
      #1;
      if (!mon_rst) begin
        if ($countones(reg_en) > 1) begin
          n_vec++;
          n_err++;
          $display("FAIL reg_en_onehot: reg_en=%0h, required at most one bit", reg_en);
        end
        if (reg_en != '0) begin
          if (wq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_write: reg_en=%0h, required no write", reg_en);
          end else begin
            mon_w = wq.pop_front();
            chk("wr_cycle", cyc, mon_w.cyc);
            chk("wr_reg_en", reg_en, NCH'(1) << mon_w.ch);
            chk("wr_note_out", note_out, mon_w.word);
            chk("wr_velocity", velocity_out, mon_w.vel);
            chk("wr_note_en", note_en, mon_w.gates);
            chk("wr_steal_count", steal_count, mon_w.steals);
          end
        end
        mon_fell = mon_prev & ~note_en;
        if (mon_fell != '0) begin
          if (fq.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL unexpected_gate_drop: fell=%0h, required none", mon_fell);
          end else begin
            mon_f = fq.pop_front();
            chk("fall_cycle", cyc, mon_f.cyc);
            chk("fall_mask", mon_fell, NCH'(1) << mon_f.ch);
            chk("fall_note_en", note_en, mon_f.gates);
            chk("fall_no_reg_en", reg_en, 0);
          end
        end
      end
      mon_prev = note_en;
    end
  end

  initial begin
    int n;
    model_reset();
    do_reset();

    send(1'b1, 60, 18'h01234, 32'h40, '1, 1'b0);
    repeat (3) @(negedge clk);

    do_reset();
    send(1'b1, 60, 18'h00111, 32'h11, 16'hFFFE, 1'b1);
    send(1'b1, 62, 18'h00222, 32'h22, 16'hFFFE, 1'b1);
    send(1'b1, 64, 18'h00333, 32'h33, 16'hFFFE, 1'b1);
    send(1'b0, 62, 18'h0, 32'h0, 16'hFFFE, 1'b0);
    send(1'b0, 62, 18'h0, 32'h0, 16'hFFFE, 1'b0);
    repeat (4) @(negedge clk);

    do_reset();
    for (int i = 0; i < NCH; i++) send(1'b1, i, WW'(i + 100), VW'(i + 1), '1, 1'b0);
    send(1'b1, 70, 18'h2AAAA, 32'hDEADBEEF, '0, 1'b0);
    send(1'b1, 71, 18'h15555, 32'hCAFEF00D, '0, 1'b0);

    do_reset();
    for (int i = 0; i < 5; i++) send(1'b1, 10 + i, WW'(i), VW'(i + 7), '1, 1'b0);
    send(1'b1, 60, 18'h0ABCD, 32'h55, '1, 1'b0);
    send(1'b1, 11 + 20, 18'h00FED, 32'h66, '1, 1'b0);
    send(1'b1, 60, 18'h3FFFF, 32'h77, '1, 1'b0);

    do_reset();
    for (int i = 0; i < 600; i++) begin
      send(($urandom_range(0, 9) < 6), 60 + $urandom_range(0, 11), WW'($urandom),
           $urandom, ($urandom_range(0, 3) == 0) ? NCH'(0) : NCH'($urandom), 1'b0);
    end

    do_reset();
    for (int i = 0; i < 300; i++) send(1'b1, i % 128, WW'($urandom), $urandom, '0, 1'b0);

    do_reset();
    for (int i = 0; i < NCH; i++) send(1'b1, 20 + i, WW'(i), VW'(i), '1, 1'b0);
    send(1'b1, 90, 18'h12345, 32'h99, '0, 1'b0);
    @(negedge clk);
    chk("kill_gate_low", note_en[0], 0);
    do_reset();
    send(1'b1, 91, 18'h00042, 32'h42, '1, 1'b0);

    n = 0;
    while ((wq.size() != 0 || fq.size() != 0) && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("queue_drain", wq.size() + fq.size(), 0);
    repeat (3) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
